// File: rtl/bcrypt_outpkt_collector_pkg.sv
// Shared types and helpers for the bcrypt output-packet collector.
// Collector FSM states, default packet geometry and the MSB index helper.
package bcrypt_outpkt_collector_pkg;

  localparam int DEF_PKT_BITS  = 96;
  localparam int DEF_OUT_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_DRAIN = 3'd0,
    ST_SCAN  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

  // Index of the highest set bit; 0 for an argument of 0.
  function automatic int msb(input int x);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (x[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcrypt_rr_select.sv
// Round-robin request picker: the first asserted request at or above ptr_i, wrapping.
// Purely combinational; the caller owns the pointer register.
module bcrypt_rr_select
  import bcrypt_outpkt_collector_pkg::*;
#(
  parameter int NUM_PROXIES = 4,
  localparam int IDX_W = msb(NUM_PROXIES - 1) + 1
) (
  input  logic [NUM_PROXIES-1:0] req_i,
  input  logic [IDX_W-1:0]       ptr_i,
  output logic                   valid_o,
  output logic [IDX_W-1:0]       idx_o
);

  int cand;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int off = NUM_PROXIES - 1; off >= 0; off--) begin
      cand = (int'(ptr_i) + off) % NUM_PROXIES;
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/bcrypt_outpkt_collector.sv
// Polls the bcrypt proxies round-robin, deserializes one proxy's result stream,
// and offers it as first-word-fall-through OUT_WIDTH words tagged with the proxy number.
module bcrypt_outpkt_collector
  import bcrypt_outpkt_collector_pkg::*;
#(
  parameter int NUM_PROXIES  = 4,
  parameter int PKT_BITS     = DEF_PKT_BITS,
  parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
  parameter int RD_LATENCY   = 2,
  parameter int DRAIN_CYCLES = 128,
  localparam int IDX_W = msb(NUM_PROXIES - 1) + 1
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [NUM_PROXIES-1:0] proxy_empty,
  input  logic [NUM_PROXIES-1:0] proxy_dout,
  output logic [NUM_PROXIES-1:0] proxy_rd_en,
  output logic [OUT_WIDTH-1:0]   out_dout,
  output logic [IDX_W-1:0]       out_proxy_num,
  output logic                   out_last,
  output logic                   out_empty,
  input  logic                   out_rd_en,
  output state_e                 dbg_state
);

  localparam int WORDS  = PKT_BITS / OUT_WIDTH;
  localparam int BIT_W  = msb(PKT_BITS - 1) + 1;
  localparam int WORD_W = msb(WORDS - 1) + 1;
  localparam int DLY_W  = msb(DRAIN_CYCLES) + 1;

  state_e                 state_q, state_d;
  logic [DLY_W-1:0]       dly_cnt_q, dly_cnt_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]      word_cnt_q, word_cnt_d;
  logic [IDX_W-1:0]       sel_q, sel_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PKT_BITS-1:0]    shreg_q, shreg_d;
  logic [NUM_PROXIES-1:0] rd_en_q, rd_en_d;
  logic [NUM_PROXIES-1:0] empty_q, dout_q;

  logic                   rr_valid;
  logic [IDX_W-1:0]       rr_idx;

  bcrypt_rr_select #(.NUM_PROXIES(NUM_PROXIES)) u_rr_select (
    .req_i   (~empty_q),
    .ptr_i   (rr_ptr_q),
    .valid_o (rr_valid),
    .idx_o   (rr_idx)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= ST_DRAIN;
      dly_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      sel_q      <= '0;
      rr_ptr_q   <= '0;
      shreg_q    <= '0;
      rd_en_q    <= '0;
      empty_q    <= '1;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      dly_cnt_q  <= dly_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      sel_q      <= sel_d;
      rr_ptr_q   <= rr_ptr_d;
      shreg_q    <= shreg_d;
      rd_en_q    <= rd_en_d;
      empty_q    <= proxy_empty;
      dout_q     <= proxy_dout;
    end
  end

  always_comb begin
    state_d    = state_q;
    dly_cnt_d  = dly_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    sel_d      = sel_q;
    rr_ptr_d   = rr_ptr_q;
    shreg_d    = shreg_q;
    rd_en_d    = '0;
    case (state_q)
      ST_DRAIN: begin
        if (dly_cnt_q == DLY_W'(DRAIN_CYCLES - 1)) begin
          dly_cnt_d = '0;
          state_d   = ST_SCAN;
        end else begin
          dly_cnt_d = dly_cnt_q + 1'b1;
        end
      end
      ST_SCAN: begin
        if (rr_valid) begin
          sel_d           = rr_idx;
          rd_en_d[rr_idx] = 1'b1;
          dly_cnt_d       = '0;
          state_d         = ST_WAIT;
        end
      end
      // The rd_en pulse cycle plus RD_LATENCY cycles, so the first stream bit
      // is sitting in dout_q when SHIFT begins.
      ST_WAIT: begin
        if (dly_cnt_q == DLY_W'(RD_LATENCY)) begin
          dly_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end else begin
          dly_cnt_d = dly_cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        shreg_d = {shreg_q[PKT_BITS-2:0], dout_q[sel_q]};
        if (bit_cnt_q == BIT_W'(PKT_BITS - 1)) begin
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          state_d    = ST_OUT;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_OUT: begin
        if (out_rd_en) begin
          if (word_cnt_q == WORD_W'(WORDS - 1)) begin
            word_cnt_d = '0;
            rr_ptr_d   = (sel_q == IDX_W'(NUM_PROXIES - 1)) ? '0 : sel_q + 1'b1;
            state_d    = ST_SCAN;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_DRAIN;
    endcase
  end

  // Word k is taken MSB-first from the buffer.
  logic [OUT_WIDTH-1:0] words [WORDS];
  for (genvar g = 0; g < WORDS; g++) begin : g_words
    assign words[g] = shreg_q[PKT_BITS-1-g*OUT_WIDTH -: OUT_WIDTH];
  end

  assign proxy_rd_en   = rd_en_q;
  assign out_dout      = words[word_cnt_q];
  assign out_proxy_num = sel_q;
  assign out_empty     = (state_q != ST_OUT);
  assign out_last      = (state_q == ST_OUT) && (word_cnt_q == WORD_W'(WORDS - 1));
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_bcrypt_outpkt_collector.sv
// Directed bench for bcrypt_outpkt_collector with a behavioural proxy model
// that streams each proxy's packet RD_LATENCY cycles after its rd_en pulse.
module tb_bcrypt_outpkt_collector;
  import bcrypt_outpkt_collector_pkg::*;

  localparam int NP    = 4;
  localparam int PKT   = 96;
  localparam int OW    = 16;
  localparam int RDL   = 2;
  localparam int DRAIN = 128;
  localparam int WORDS = PKT / OW;

  // clock / reset
  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  logic [NP-1:0] proxy_empty = '1;
  logic [NP-1:0] proxy_dout  = '0;
  logic [NP-1:0] proxy_rd_en;
  logic [OW-1:0] out_dout;
  logic [1:0]    out_proxy_num;
  logic          out_last;
  logic          out_empty;
  logic          out_rd_en;
  state_e        dbg_state;

  logic [PKT-1:0] pkt [NP];
  int req_cnt [NP] = '{default: 0};
  int rd_cnt  [NP] = '{default: 0};
  int ph      [NP] = '{default: 0};

  int total = 0;
  int bad   = 0;

  bcrypt_outpkt_collector #(
    .NUM_PROXIES(NP), .PKT_BITS(PKT), .OUT_WIDTH(OW),
    .RD_LATENCY(RDL), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .CLK           (CLK),
    .reset         (reset),
    .proxy_empty   (proxy_empty),
    .proxy_dout    (proxy_dout),
    .proxy_rd_en   (proxy_rd_en),
    .out_dout      (out_dout),
    .out_proxy_num (out_proxy_num),
    .out_last      (out_last),
    .out_empty     (out_empty),
    .out_rd_en     (out_rd_en),
    .dbg_state     (dbg_state)
  );

  // Proxy model: no reset, holds data until read, bit 0 valid RDL cycles after rd_en.
  always @(negedge CLK) begin
    for (int i = 0; i < NP; i++) begin
      if (ph[i] >= RDL && ph[i] < RDL + PKT) proxy_dout[i] = pkt[i][PKT-1-(ph[i]-RDL)];
      else proxy_dout[i] = 1'b0;
      if (ph[i] > 0) ph[i] = (ph[i] >= RDL + PKT) ? 0 : ph[i] + 1;
      if (proxy_rd_en[i]) begin
        ph[i] = 1;
        rd_cnt[i] = rd_cnt[i] + 1;
      end
      proxy_empty[i] = (req_cnt[i] <= rd_cnt[i]);
    end
  end

  // driver tasks
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [PKT-1:0] obs, input logic [PKT-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rd(input int budget, output logic [NP-1:0] v, output int n);
    v = '0;
    n = 0;
    while (n < budget && v == '0) begin
      tick();
      n++;
      v = proxy_rd_en;
    end
  endtask

  task automatic wait_out(input string tag, input int budget);
    int n;
    n = 0;
    while (n < budget && out_empty) begin
      tick();
      n++;
    end
    chk({tag, " out_ready"}, out_empty, 1'b0);
  endtask

  task automatic read_pkt(input string tag, input logic [PKT-1:0] p, input logic [1:0] num);
    logic [OW-1:0] ew;
    for (int k = 0; k < WORDS; k++) begin
      ew = p[PKT-1-k*OW -: OW];
      chk($sformatf("%s w%0d dout", tag, k), out_dout, ew);
      chk($sformatf("%s w%0d num", tag, k), out_proxy_num, num);
      chk($sformatf("%s w%0d last", tag, k), out_last, (k == WORDS - 1));
      out_rd_en = 1'b1;
      tick();
      out_rd_en = 1'b0;
    end
    chk({tag, " empty_after"}, out_empty, 1'b1);
  endtask

  logic [NP-1:0] v;
  logic [NP-1:0] exp_v;
  int n;
  int viol;
  int rr_idx [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset     = 1'b1;
    out_rd_en = 1'b0;
    pkt[0] = 96'hDEAD_BEEF_0001_8000_7FFE_C3C3;
    pkt[1] = 96'h0F0F_F0F0_1234_5678_9ABC_DEF0;
    pkt[2] = 96'hA5A5_0123_4567_89AB_CDEF_F00D;
    pkt[3] = 96'h8001_4002_2004_1008_0810_0420;
    req_cnt[1] = 1;
    repeat (3) tick();

    // reset state
    chk("rst rd_en", proxy_rd_en, 4'b0000);
    chk("rst empty", out_empty, 1'b1);
    chk("rst dout", out_dout, 16'h0000);
    chk("rst num", out_proxy_num, 2'd0);
    chk("rst last", out_last, 1'b0);
    chk("rst state", dbg_state, ST_DRAIN);
    reset = 1'b0;

    // drain: proxy 1 pending from the start, first read only after the quiet period
    wait_rd(DRAIN + 40, v, n);
    chk("drain early_rd", (n <= DRAIN), 1'b0);
    chk("drain rd_en", v, 4'b0010);
    tick();
    chk("rd_en one_cycle", proxy_rd_en, 4'b0000);
    wait_out("p1", 200);
    read_pkt("p1", pkt[1], 2'd1);

    // single packet from proxy 2; out_rd_en while empty must be ignored
    req_cnt[2] = req_cnt[2] + 1;
    wait_rd(50, v, n);
    chk("single rd_en", v, 4'b0100);
    out_rd_en = 1'b1;
    repeat (20) tick();
    out_rd_en = 1'b0;
    wait_out("p2", 200);
    chk("p2 first_word", out_dout, 16'hA5A5);
    read_pkt("p2", pkt[2], 2'd2);

    // backpressure: proxy 3 packet held 500 cycles while every proxy is pending
    req_cnt[3] = req_cnt[3] + 1;
    wait_rd(50, v, n);
    chk("bp rd_en", v, 4'b1000);
    wait_out("bp", 200);
    req_cnt[0] = req_cnt[0] + 2;
    req_cnt[1] = req_cnt[1] + 1;
    req_cnt[2] = req_cnt[2] + 1;
    req_cnt[3] = req_cnt[3] + 1;
    viol = 0;
    repeat (500) begin
      tick();
      if (out_dout !== 16'h8001 || out_empty !== 1'b0 || proxy_rd_en !== 4'b0000) viol++;
    end
    chk("bp hold_violations", viol, 0);
    read_pkt("p3", pkt[3], 2'd3);

    // round robin with all four pending
    for (int j = 0; j < 5; j++) begin
      exp_v = '0;
      exp_v[rr_idx[j]] = 1'b1;
      wait_rd(50, v, n);
      chk($sformatf("rr%0d rd_en", j), v, exp_v);
      wait_out($sformatf("rr%0d", j), 200);
      read_pkt($sformatf("rr%0d", j), pkt[rr_idx[j]], 2'(rr_idx[j]));
    end

    // wrap: only proxy 3, then proxies 0 and 1 together -> pointer must be back at 0
    req_cnt[3] = req_cnt[3] + 1;
    wait_rd(50, v, n);
    chk("wrap rd_en3", v, 4'b1000);
    wait_out("wrap3", 200);
    req_cnt[0] = req_cnt[0] + 1;
    req_cnt[1] = req_cnt[1] + 1;
    read_pkt("wrap3", pkt[3], 2'd3);
    wait_rd(50, v, n);
    chk("wrap rd_en0", v, 4'b0001);
    wait_out("wrap0", 200);
    read_pkt("wrap0", pkt[0], 2'd0);
    wait_rd(50, v, n);
    chk("wrap rd_en1", v, 4'b0010);
    wait_out("wrap1", 200);
    read_pkt("wrap1", pkt[1], 2'd1);

    // reset at bit 40 of a proxy 2 packet
    req_cnt[2] = req_cnt[2] + 1;
    wait_rd(50, v, n);
    chk("abort rd_en", v, 4'b0100);
    repeat (RDL + 1 + 40) tick();
    chk("abort in_shift", dbg_state, ST_SHIFT);
    reset = 1'b1;
    #1;
    chk("abort empty", out_empty, 1'b1);
    chk("abort state", dbg_state, ST_DRAIN);
    chk("abort rd_en_low", proxy_rd_en, 4'b0000);
    tick();
    tick();
    reset = 1'b0;
    repeat (100) tick();
    pkt[2] = 96'h0123_4567_89AB_CDEF_FEDC_BA98;
    req_cnt[2] = req_cnt[2] + 1;
    wait_rd(DRAIN, v, n);
    chk("post_abort early_rd", (100 + n <= DRAIN), 1'b0);
    chk("post_abort rd_en", v, 4'b0100);
    wait_out("post_abort", 200);
    read_pkt("post_abort", pkt[2], 2'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
